// File: rtl/jump_pc_sequencer_if.sv
// Fetch/redirect bundle between decode/branch resolution and the PC sequencer.
//
// Signals:
//   fetch_ready          fetch stage accepts pc this cycle
//   pc, pc_valid         current fetch address and its valid flag
//   jmp, jmp_index, jal  J/JAL redirect, instruction-index field, link request
//   br_taken, br_offset  taken-branch redirect with signed word offset
//   jr, jr_addr          jump-register redirect and register target
//   link_we, link_addr   one-cycle link-register write strobe and return address
//   addr_err             one-cycle misaligned-JR strobe
//   in_slot              sequencer is issuing the delay-slot instruction
//
// Modports: master drives fetch_ready and redirects; slave is the sequencer.
interface jump_pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IMM_W  = 26,
    parameter int unsigned OFF_W  = 16
);
    logic              fetch_ready;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              jmp;
    logic [IMM_W-1:0]  jmp_index;
    logic              jal;
    logic              br_taken;
    logic [OFF_W-1:0]  br_offset;
    logic              jr;
    logic [ADDR_W-1:0] jr_addr;
    logic              link_we;
    logic [ADDR_W-1:0] link_addr;
    logic              addr_err;
    logic              in_slot;

    modport master (
        output fetch_ready, jmp, jmp_index, jal, br_taken, br_offset, jr, jr_addr,
        input  pc, pc_valid, link_we, link_addr, addr_err, in_slot
    );

    modport slave (
        input  fetch_ready, jmp, jmp_index, jal, br_taken, br_offset, jr, jr_addr,
        output pc, pc_valid, link_we, link_addr, addr_err, in_slot
    );
endinterface

// File: rtl/jump_pc_sequencer.sv
// Registered program-counter sequencer for a 32-bit MIPS pipeline.
// Holds the fetch address, advances it by 4 on each accepted fetch and applies
// J/JAL, JR and taken-branch redirects (priority jr > jmp > br_taken).
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    jump_pc_sequencer_if.slave (fetch handshake, redirects, link, status)
//
// Build option: define JMP_DELAY_SLOT_EN for MIPS branch-delay-slot semantics
// (redirect applied after the next sequential fetch, link = pc+8). When
// undefined, redirects take effect on the next cycle and link = pc+4.
module jump_pc_sequencer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       IMM_W    = 26,
    parameter int unsigned       OFF_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
    input logic               clk,
    input logic               reset,
    jump_pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StBoot, StRun, StSlot} state_e;

`ifdef JMP_DELAY_SLOT_EN
    localparam logic [ADDR_W-1:0] LinkOfs = ADDR_W'(8);
`else
    localparam logic [ADDR_W-1:0] LinkOfs = ADDR_W'(4);
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              link_we_q, link_we_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic              addr_err_q, addr_err_d;
`ifdef JMP_DELAY_SLOT_EN
    logic [ADDR_W-1:0] target_q, target_d;
    logic              in_slot_q, in_slot_d;
`endif

    logic              accept;
    logic              redirect;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] upper_mask;
    logic [ADDR_W-1:0] br_ofs_ext;
    logic [ADDR_W-1:0] jmp_tgt, br_tgt, jr_tgt, target;

    assign accept   = pc_valid_q & bus.fetch_ready;
    assign redirect = bus.jr | bus.jmp | bus.br_taken;
    assign pc4      = pc_q + ADDR_W'(4);

    // Bits above the jump field come from pc4; mask form stays legal when
    // ADDR_W == IMM_W+2 (mask collapses to zero).
    assign upper_mask = ~((ADDR_W'(1) << (IMM_W + 2)) - ADDR_W'(1));
    assign jmp_tgt    = (pc4 & upper_mask) | (ADDR_W'(bus.jmp_index) << 2);
    assign br_ofs_ext = ADDR_W'($signed(bus.br_offset));
    assign br_tgt     = pc4 + (br_ofs_ext << 2);
    assign jr_tgt     = {bus.jr_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        target = br_tgt;
        if (bus.jr) begin
            target = jr_tgt;
        end else if (bus.jmp) begin
            target = jmp_tgt;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        link_we_d   = 1'b0;
        link_addr_d = link_addr_q;
        addr_err_d  = 1'b0;
`ifdef JMP_DELAY_SLOT_EN
        target_d    = target_q;
`endif
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (accept) begin
                    if (bus.jmp && bus.jal) begin
                        link_we_d   = 1'b1;
                        link_addr_d = pc_q + LinkOfs;
                    end
                    addr_err_d = bus.jr && (bus.jr_addr[1:0] != 2'b00);
                    if (redirect) begin
`ifdef JMP_DELAY_SLOT_EN
                        // Fetch the delay-slot instruction first, then the target.
                        pc_d     = pc4;
                        target_d = target;
                        state_d  = StSlot;
`else
                        pc_d     = target;
`endif
                    end else begin
                        pc_d = pc4;
                    end
                end
            end
`ifdef JMP_DELAY_SLOT_EN
            StSlot: begin
                // Redirect inputs belong to the slot instruction and are ignored.
                if (accept) begin
                    pc_d    = target_q;
                    state_d = StRun;
                end
            end
`endif
            default: begin
                state_d = StBoot;
            end
        endcase
        pc_valid_d = (state_d != StBoot);
`ifdef JMP_DELAY_SLOT_EN
        in_slot_d  = (state_d == StSlot);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_addr_q <= '0;
            addr_err_q  <= 1'b0;
`ifdef JMP_DELAY_SLOT_EN
            target_q    <= '0;
            in_slot_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
            addr_err_q  <= addr_err_d;
`ifdef JMP_DELAY_SLOT_EN
            target_q    <= target_d;
            in_slot_q   <= in_slot_d;
`endif
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = pc_valid_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_addr = link_addr_q;
    assign bus.addr_err  = addr_err_q;
`ifdef JMP_DELAY_SLOT_EN
    assign bus.in_slot   = in_slot_q;
`else
    assign bus.in_slot   = 1'b0;
`endif

endmodule
